// File: rtl/m_stage_reg_if.sv
// rtl/m_stage_reg_if.sv - Execute-to-Memory stage register bundle interface
interface m_stage_reg_if #(
    parameter int DATA_W  = 64,
    parameter int STAT_W  = 3,
    parameter int ICODE_W = 4,
    parameter int REG_W   = 4,
    parameter int CNT_W   = 16
);
    // Pipeline control
    logic               M_stall;
    logic               M_bubble;
    logic               cnt_clr;

    // Execute-stage bundle
    logic [STAT_W-1:0]  E_stat;
    logic [ICODE_W-1:0] E_icode;
    logic               e_cnd;
    logic [DATA_W-1:0]  e_valE;
    logic [DATA_W-1:0]  E_valA;
    logic [REG_W-1:0]   e_dstE;
    logic [REG_W-1:0]   E_dstM;

    // Memory-stage bundle
    logic [STAT_W-1:0]  M_stat;
    logic [ICODE_W-1:0] M_icode;
    logic               M_cnd;
    logic [DATA_W-1:0]  M_valE;
    logic [DATA_W-1:0]  M_valA;
    logic [REG_W-1:0]   M_dstE;
    logic [REG_W-1:0]   M_dstM;
    logic               M_valid;
    logic               M_exc;

    // Performance counters
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   bubble_cnt;

    modport master (
        output M_stall, M_bubble, cnt_clr,
        output E_stat, E_icode, e_cnd, e_valE, E_valA, e_dstE, E_dstM,
        input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
        input  M_valid, M_exc, stall_cnt, bubble_cnt
    );

    modport slave (
        input  M_stall, M_bubble, cnt_clr,
        input  E_stat, E_icode, e_cnd, e_valE, E_valA, e_dstE, E_dstM,
        output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
        output M_valid, M_exc, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/m_stage_reg.sv
// rtl/m_stage_reg.sv - Y86-64 Execute-to-Memory pipeline register with stall/bubble counters
module m_stage_reg #(
    parameter int                 DATA_W    = 64,
    parameter int                 STAT_W    = 3,
    parameter int                 ICODE_W   = 4,
    parameter int                 REG_W     = 4,
    parameter int                 CNT_W     = 16,
    parameter logic [STAT_W-1:0]  STAT_AOK  = 3'h1,
    parameter logic [ICODE_W-1:0] ICODE_NOP = 4'h1,
    parameter logic [REG_W-1:0]   RNONE     = 4'hF
) (
    input  logic          clk,
    input  logic          rst_n,
    m_stage_reg_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Bubble wins over stall; the stall counter only sees stalls that actually hold
    logic do_bubble;
    logic do_stall;

    assign do_bubble = bus.M_bubble;
    assign do_stall  = bus.M_stall & ~bus.M_bubble;

    // Pipeline bundle: bubble loads NOP values, stall holds, otherwise load from execute
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.M_stat  <= STAT_AOK;
            bus.M_icode <= ICODE_NOP;
            bus.M_cnd   <= 1'b0;
            bus.M_valE  <= '0;
            bus.M_valA  <= '0;
            bus.M_dstE  <= RNONE;
            bus.M_dstM  <= RNONE;
            bus.M_valid <= 1'b0;
            bus.M_exc   <= 1'b0;
        end else if (do_bubble) begin
            bus.M_stat  <= STAT_AOK;
            bus.M_icode <= ICODE_NOP;
            bus.M_cnd   <= 1'b0;
            bus.M_valE  <= '0;
            bus.M_valA  <= '0;
            bus.M_dstE  <= RNONE;
            bus.M_dstM  <= RNONE;
            bus.M_valid <= 1'b0;
            bus.M_exc   <= 1'b0;
        end else if (!do_stall) begin
            bus.M_stat  <= bus.E_stat;
            bus.M_icode <= bus.E_icode;
            bus.M_cnd   <= bus.e_cnd;
            bus.M_valE  <= bus.e_valE;
            bus.M_valA  <= bus.E_valA;
            bus.M_dstE  <= bus.e_dstE;
            bus.M_dstM  <= bus.E_dstM;
            bus.M_valid <= 1'b1;
            // Exception flag is registered alongside the status it describes
            bus.M_exc   <= (bus.E_stat != STAT_AOK);
        end
    end

    // Saturating event counters; a clear on the same edge beats any increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.stall_cnt  <= '0;
            bus.bubble_cnt <= '0;
        end else if (bus.cnt_clr) begin
            bus.stall_cnt  <= '0;
            bus.bubble_cnt <= '0;
        end else begin
            if (do_stall && (bus.stall_cnt != CNT_MAX)) begin
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
            end
            if (do_bubble && (bus.bubble_cnt != CNT_MAX)) begin
                bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_m_stage_reg.sv
// tb/tb_m_stage_reg.sv - directed self-checking bench for m_stage_reg
module tb_m_stage_reg;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    m_stage_reg_if #(.CNT_W(4)) bus ();

    m_stage_reg #(.CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_nop(input string tag);
        check({tag, " stat"},  64'(bus.M_stat),  64'h1);
        check({tag, " icode"}, 64'(bus.M_icode), 64'h1);
        check({tag, " cnd"},   64'(bus.M_cnd),   64'h0);
        check({tag, " valE"},  bus.M_valE,       64'h0);
        check({tag, " valA"},  bus.M_valA,       64'h0);
        check({tag, " dstE"},  64'(bus.M_dstE),  64'hF);
        check({tag, " dstM"},  64'(bus.M_dstM),  64'hF);
        check({tag, " valid"}, 64'(bus.M_valid), 64'h0);
        check({tag, " exc"},   64'(bus.M_exc),   64'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset held with arbitrary inputs
        rst_n        = 1'b0;
        bus.M_stall  = 1'b0;
        bus.M_bubble = 1'b0;
        bus.cnt_clr  = 1'b0;
        bus.E_stat   = 3'h4;
        bus.E_icode  = 4'h7;
        bus.e_cnd    = 1'b1;
        bus.e_valE   = 64'hDEAD_BEEF;
        bus.E_valA   = 64'hCAFE;
        bus.e_dstE   = 4'h3;
        bus.E_dstM   = 4'h5;
        step();
        step();
        check_nop("reset");
        check("reset stall_cnt",  64'(bus.stall_cnt),  64'h0);
        check("reset bubble_cnt", 64'(bus.bubble_cnt), 64'h0);

        // Release mid-cycle, load one instruction, then reset between edges
        rst_n = 1'b1;
        step();
        check("post-reset load icode", 64'(bus.M_icode), 64'h7);
        check("post-reset load valid", 64'(bus.M_valid), 64'h1);
        check("post-reset load exc",   64'(bus.M_exc),   64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_nop("async reset");
        #1;
        rst_n = 1'b1;

        // Load
        bus.E_stat  = 3'h1;
        bus.E_icode = 4'h6;
        bus.e_cnd   = 1'b1;
        bus.e_valE  = 64'h1234;
        bus.E_valA  = 64'hABCD;
        bus.e_dstE  = 4'h2;
        bus.E_dstM  = 4'hF;
        step();
        check("load stat",  64'(bus.M_stat),  64'h1);
        check("load icode", 64'(bus.M_icode), 64'h6);
        check("load cnd",   64'(bus.M_cnd),   64'h1);
        check("load valE",  bus.M_valE,       64'h1234);
        check("load valA",  bus.M_valA,       64'hABCD);
        check("load dstE",  64'(bus.M_dstE),  64'h2);
        check("load dstM",  64'(bus.M_dstM),  64'hF);
        check("load valid", 64'(bus.M_valid), 64'h1);
        check("load exc",   64'(bus.M_exc),   64'h0);

        // Stall for three edges while inputs keep changing
        bus.e_valE  = 64'h5;
        bus.E_icode = 4'h3;
        step();
        check("stall preload valE", bus.M_valE, 64'h5);
        bus.M_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.e_valE  = 64'h100 + 64'(i);
            bus.E_icode = 4'h8;
            bus.E_stat  = 3'h3;
            step();
            check("stall hold valE",  bus.M_valE,       64'h5);
            check("stall hold icode", 64'(bus.M_icode), 64'h3);
            check("stall hold exc",   64'(bus.M_exc),   64'h0);
        end
        check("stall_cnt after 3", 64'(bus.stall_cnt), 64'h3);

        // Stall and bubble together: bubble wins
        bus.M_bubble = 1'b1;
        step();
        check_nop("bubble+stall");
        check("bubble+stall bubble_cnt", 64'(bus.bubble_cnt), 64'h1);
        check("bubble+stall stall_cnt",  64'(bus.stall_cnt),  64'h3);

        // Exception on halt status, cleared by a bubble
        bus.M_stall  = 1'b0;
        bus.M_bubble = 1'b0;
        bus.E_stat   = 3'h2;
        bus.E_icode  = 4'h0;
        step();
        check("halt exc",   64'(bus.M_exc),   64'h1);
        check("halt stat",  64'(bus.M_stat),  64'h2);
        check("halt valid", 64'(bus.M_valid), 64'h1);
        bus.M_bubble = 1'b1;
        step();
        check("bubble clears exc",  64'(bus.M_exc),      64'h0);
        check("bubble clears stat", 64'(bus.M_stat),     64'h1);
        check("bubble_cnt 2",       64'(bus.bubble_cnt), 64'h2);

        // Stall counter saturation with a 4-bit counter
        bus.M_bubble = 1'b0;
        bus.M_stall  = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("stall_cnt saturates", 64'(bus.stall_cnt), 64'hF);
        check("saturate hold icode", 64'(bus.M_icode),   64'h1);

        // Clear beats the stall increment on the same edge
        bus.cnt_clr = 1'b1;
        step();
        check("clr stall_cnt",  64'(bus.stall_cnt),  64'h0);
        check("clr bubble_cnt", 64'(bus.bubble_cnt), 64'h0);
        bus.cnt_clr = 1'b0;
        step();
        check("stall_cnt after clr", 64'(bus.stall_cnt), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
